ysyx_22040750_npc_gen: RTL and testbench
========================================

# ysyx_22040750_npc_gen

Parametrised next-PC generator with an output buffer. It sits between the ID-stage PC-select logic and the IF stage. It computes the dynamic next PC from snpc, branch/jal, jalr or trap-vector sources and checks target alignment. Results are queued in a DEPTH-entry FIFO with a zero-latency bypass, so a stalled IF stage never loses a redirect; a flush drops every pending redirect.

## Interface
- PC_W, 32: PC / output address width.
- XLEN, 64: width of rs1, immediate and trap-vector operands; only bits [PC_W-1:0] are used.
- DEPTH, 2: FIFO entries; power of two, 2..8.

- I_clk  input  1  clock, rising edge.
- I_rst_n  input  1  synchronous, active-low reset.
- I_flush  input  1  drop all queued and incoming redirects this cycle.
- I_in_valid  input  1  source operands and select are valid.
- O_in_ready  output  1  generator can accept a new request.
- I_dnpc_sel  input  5  one-hot select: [4] trap/csr, [3] jalr, [2] jal, [1] branch, [0] snpc.
- I_pc  input  PC_W  PC of the instruction in ID; base for jal/branch.
- I_snpc  input  PC_W  sequential next PC.
- I_rs1_data  input  XLEN  jalr base.
- I_imm  input  XLEN  sign-extended offset.
- I_intr_pc  input  XLEN  trap/mret target from the CSR unit.
- O_dnpc_valid  output  1  O_dnpc is valid.
- I_dnpc_ready  input  1  IF stage accepts O_dnpc.
- O_dnpc  output  PC_W  next PC.
- O_misalign  output  1  O_dnpc violates instruction alignment; qualified by O_dnpc_valid.
- O_count  output  $clog2(DEPTH+1)  number of occupied FIFO entries.

## Operation
- Target selection, with priority [4]>[3]>[2]>[1]>[0]; non-one-hot selects resolve by this priority:
  - [4]: I_intr_pc[PC_W-1:0].
  - [3]: (I_rs1_data + I_imm)[PC_W-1:0] with bit 0 cleared.
  - [2] or [1]: I_pc + I_imm[PC_W-1:0].
  - [0], or all-zero select: I_snpc.
- Arithmetic is modulo 2^PC_W; carry out is discarded and wraps silently.
- Misalignment is target[1] without RVC, or target[0] in all modes after the jalr clear.
  - The misalign flag is stored with the entry and travels with it.
  - The block never suppresses or corrects a misaligned target; the trap unit consumes O_misalign.
- FIFO holds {target, misalign} pairs.
  - O_in_ready = (O_count != DEPTH) && !I_flush.
  - Push happens on I_in_valid && O_in_ready.
- Bypass: when the FIFO is empty, O_dnpc_valid = I_in_valid && !I_flush and O_dnpc/O_misalign come directly from the combinational result.
  - If I_dnpc_ready is also high, the request is consumed without being written.
  - Otherwise it is written into the FIFO.
- Non-empty FIFO: output is the head entry.
  - Pop on O_dnpc_valid && I_dnpc_ready.
  - Simultaneous push and pop leave O_count unchanged, and order is strictly preserved.
- Full FIFO: O_in_ready=0. A same-cycle pop does not open a slot for input in that cycle; ready rises the next cycle.
- Flush: read/write pointers and O_count are cleared at the clock edge.
  - O_dnpc_valid=0 and O_in_ready=0 during the flush cycle.
  - Input in the flush cycle is discarded.
  - Flush has priority over push and pop.

## Timing
- Reset (I_rst_n=0 at a rising edge): pointers=0, O_count=0, storage contents don't-care.
  - Outputs during reset: O_dnpc_valid=0, O_in_ready=0, O_misalign=0, O_dnpc=0.
  - Reset mid-operation discards all entries; the cycle after release O_in_ready=1.
- Latency:
  - Bypass: 0 cycles.
  - Queued: an entry becomes head-visible the cycle after its push, provided it is at the head.
- O_in_ready and O_count depend only on state and I_flush, never on I_in_valid or I_dnpc_ready, so there is no combinational loop.
- O_dnpc_valid and O_dnpc have a combinational path from the inputs only while the FIFO is empty.
- Valid/ready rule: once O_dnpc_valid=1 from a FIFO entry, O_dnpc holds stable until it is popped or flushed.

## Configuration
- YSYX_22040750_NPC_RVC_EN defined: 2-byte alignment; O_misalign = target[0] only.
- Undefined: 4-byte alignment; O_misalign = target[1] | target[0].

## Test plan
- Bypass: FIFO empty, I_dnpc_ready=1, sel=00100, I_pc=0x80000010, imm=0x20 -> same cycle O_dnpc_valid=1, O_dnpc=0x80000030, O_count stays 0.
- jalr clear and misalign check, with RVC undefined:
  - sel=01000, rs1=0x80001003, imm=0 -> O_dnpc=0x80001002, O_misalign=1.
  - Same stimulus with YSYX_22040750_NPC_RVC_EN defined -> O_misalign=0.
- Backpressure fill, DEPTH=2, I_dnpc_ready=0:
  - Push snpc targets 0x100, then 0x104 -> O_count=2, O_in_ready=0.
  - Raise ready -> outputs 0x100 then 0x104 on consecutive cycles.
- Flush with 2 entries queued plus I_in_valid=1: assert I_flush -> O_dnpc_valid=0 that cycle; next cycle O_count=0, the input is not seen, O_in_ready=1.
- Priority and wrap:
  - sel=10001, intr_pc=0x80000100 -> O_dnpc=0x80000100.
  - sel=00010, pc=0xFFFFFFFC, imm=8 -> O_dnpc=0x00000004.
- Reset with 1 entry queued: hold I_rst_n=0 for 1 cycle -> O_dnpc_valid=0, O_count=0, O_dnpc=0; the next accepted request bypasses correctly.

Source files
------------

// File: rtl/ysyx_22040750_npc_gen_if.sv
// Handshake bundle between the ID-stage PC-select logic, the next-PC generator and IF.
// master = ID/IF side driving requests and accepting results, slave = the generator.
interface ysyx_22040750_npc_gen_if #(
    parameter int PC_W  = 32,
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
);
    logic                         I_flush;
    logic                         I_in_valid;
    logic                         O_in_ready;
    logic [4:0]                   I_dnpc_sel;
    logic [PC_W-1:0]              I_pc;
    logic [PC_W-1:0]              I_snpc;
    logic [XLEN-1:0]              I_rs1_data;
    logic [XLEN-1:0]              I_imm;
    logic [XLEN-1:0]              I_intr_pc;
    logic                         O_dnpc_valid;
    logic                         I_dnpc_ready;
    logic [PC_W-1:0]              O_dnpc;
    logic                         O_misalign;
    logic [$clog2(DEPTH+1)-1:0]   O_count;

    modport master (
        output I_flush, I_in_valid, I_dnpc_sel, I_pc, I_snpc, I_rs1_data, I_imm, I_intr_pc,
               I_dnpc_ready,
        input  O_in_ready, O_dnpc_valid, O_dnpc, O_misalign, O_count
    );

    modport slave (
        input  I_flush, I_in_valid, I_dnpc_sel, I_pc, I_snpc, I_rs1_data, I_imm, I_intr_pc,
               I_dnpc_ready,
        output O_in_ready, O_dnpc_valid, O_dnpc, O_misalign, O_count
    );
endinterface

// File: rtl/ysyx_22040750_npc_gen.sv
// Next-PC generator with a DEPTH-entry redirect FIFO and zero-latency bypass when empty.
// Define YSYX_22040750_NPC_RVC_EN for 2-byte instruction alignment (default: 4-byte).
module ysyx_22040750_npc_gen #(
    parameter int PC_W  = 32,
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                   I_clk,
    input  logic                   I_rst_n,
    ysyx_22040750_npc_gen_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] mem_tgt [DEPTH];
    logic            mem_mis [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [PC_W-1:0] jalr_sum;
    logic [PC_W-1:0] target;
    logic            target_mis;
    logic            empty;
    logic            full;
    logic            in_ready;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            unused_bits;

    assign jalr_sum = bus.I_rs1_data[PC_W-1:0] + bus.I_imm[PC_W-1:0];

    always_comb begin
        target = bus.I_snpc;
        if (bus.I_dnpc_sel[4]) begin
            target = bus.I_intr_pc[PC_W-1:0];
        end else if (bus.I_dnpc_sel[3]) begin
            target = {jalr_sum[PC_W-1:1], 1'b0};
        end else if (bus.I_dnpc_sel[2] || bus.I_dnpc_sel[1]) begin
            target = bus.I_pc + bus.I_imm[PC_W-1:0];
        end
    end

`ifdef YSYX_22040750_NPC_RVC_EN
    assign target_mis = target[0];
`else
    assign target_mis = target[1] | target[0];
`endif

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Ready depends only on state and flush, keeping IF/ID free of a combinational loop.
    assign in_ready  = I_rst_n && !full && !bus.I_flush;
    assign out_valid = I_rst_n && !bus.I_flush && (empty ? bus.I_in_valid : 1'b1);

    assign push  = bus.I_in_valid && in_ready;
    assign pop   = out_valid && bus.I_dnpc_ready && !empty;
    assign wr_en = push && !(empty && bus.I_dnpc_ready);

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.I_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + CW'(1);
            else if (!wr_en && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge I_clk) begin
        if (wr_en) begin
            mem_tgt[wr_ptr] <= target;
            mem_mis[wr_ptr] <= target_mis;
        end
    end

    assign bus.O_in_ready   = in_ready;
    assign bus.O_dnpc_valid = out_valid;
    assign bus.O_count      = count;
    assign bus.O_dnpc       = !I_rst_n ? '0   : (empty ? target     : mem_tgt[rd_ptr]);
    assign bus.O_misalign   = !I_rst_n ? 1'b0 : (empty ? target_mis : mem_mis[rd_ptr]);

    assign unused_bits = ^{bus.I_rs1_data[XLEN-1:PC_W], bus.I_imm[XLEN-1:PC_W],
                           bus.I_intr_pc[XLEN-1:PC_W], jalr_sum[0]};
endmodule

// File: tb/tb_ysyx_22040750_npc_gen.sv
// Scoreboard bench for the next-PC generator: directed plan cases, then randomized traffic.
module tb_ysyx_22040750_npc_gen;
    localparam int PC_W  = 32;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;

    typedef struct {
        logic [PC_W-1:0] tgt;
        logic            mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    ysyx_22040750_npc_gen_if #(.PC_W(PC_W), .XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    ysyx_22040750_npc_gen #(.PC_W(PC_W), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus.slave)
    );

    function automatic exp_t model(input logic [4:0] sel, input longint unsigned pc,
                                   input longint unsigned snpc, input longint unsigned rs1,
                                   input longint unsigned imm, input longint unsigned intr);
        longint unsigned m;
        longint unsigned t;
        exp_t e;
        m = (64'd1 << PC_W) - 64'd1;
        if (sel[4])                t = intr & m;
        else if (sel[3])           t = ((rs1 + imm) & m) & ~64'd1;
        else if (sel[2] || sel[1]) t = (pc + imm) & m;
        else                       t = snpc & m;
        e.tgt = t[PC_W-1:0];
`ifdef YSYX_22040750_NPC_RVC_EN
        e.mis = t[0];
`else
        e.mis = t[1] | t[0];
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares against the queue model on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic exp_ready;
        if (!rst_n) begin
            check("rst_valid", 64'(bus.O_dnpc_valid), 64'd0);
            check("rst_ready", 64'(bus.O_in_ready), 64'd0);
            check("rst_dnpc", 64'(bus.O_dnpc), 64'd0);
            check("rst_mis", 64'(bus.O_misalign), 64'd0);
            sbq.delete();
        end else begin
            exp_ready = (sbq.size() != DEPTH) && !bus.I_flush;
            check("in_ready", 64'(bus.O_in_ready), 64'(exp_ready));
            check("count", 64'(bus.O_count), 64'(sbq.size()));
            if (bus.I_flush) begin
                check("flush_valid", 64'(bus.O_dnpc_valid), 64'd0);
                sbq.delete();
            end else begin
                if (bus.I_in_valid && exp_ready)
                    sbq.push_back(model(bus.I_dnpc_sel, 64'(bus.I_pc), 64'(bus.I_snpc),
                                        bus.I_rs1_data, bus.I_imm, bus.I_intr_pc));
                check("dnpc_valid", 64'(bus.O_dnpc_valid), 64'(sbq.size() > 0));
                if (bus.O_dnpc_valid && sbq.size() > 0) begin
                    e = sbq[0];
                    check("dnpc", 64'(bus.O_dnpc), 64'(e.tgt));
                    check("misalign", 64'(bus.O_misalign), 64'(e.mis));
                    if (bus.I_dnpc_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #3;
    endtask

    task automatic drv(input logic v, input logic [4:0] sel, input logic [PC_W-1:0] pc,
                       input logic [PC_W-1:0] snpc, input logic [XLEN-1:0] rs1,
                       input logic [XLEN-1:0] imm, input logic [XLEN-1:0] intr,
                       input logic rdy, input logic fl);
        bus.I_in_valid   = v;
        bus.I_dnpc_sel   = sel;
        bus.I_pc         = pc;
        bus.I_snpc       = snpc;
        bus.I_rs1_data   = rs1;
        bus.I_imm        = imm;
        bus.I_intr_pc    = intr;
        bus.I_dnpc_ready = rdy;
        bus.I_flush      = fl;
    endtask

    initial begin
        logic [4:0]      sel;
        logic [PC_W-1:0] rpc;
        logic [XLEN-1:0] rimm;
        drv(0, 5'b0, '0, '0, '0, '0, '0, 0, 0);
        rst_n = 1'b0;
        step();
        probe();
        check("reset_valid", 64'(bus.O_dnpc_valid), 64'd0);
        check("reset_dnpc", 64'(bus.O_dnpc), 64'd0);

        // Bypass with ready
        step();
        rst_n = 1'b1;
        drv(1, 5'b00100, 32'h8000_0010, 32'h0, 64'h0, 64'h20, 64'h0, 1, 0);
        probe();
        check("bypass_valid", 64'(bus.O_dnpc_valid), 64'd1);
        check("bypass_dnpc", 64'(bus.O_dnpc), 64'h8000_0030);
        step();
        drv(0, 5'b0, '0, '0, '0, '0, '0, 1, 0);
        probe();
        check("bypass_count", 64'(bus.O_count), 64'd0);

        // jalr bit-0 clear and alignment
        step();
        drv(1, 5'b01000, '0, '0, 64'h8000_1003, 64'h0, 64'h0, 1, 0);
        probe();
        check("jalr_dnpc", 64'(bus.O_dnpc), 64'h8000_1002);
`ifdef YSYX_22040750_NPC_RVC_EN
        check("jalr_mis", 64'(bus.O_misalign), 64'd0);
`else
        check("jalr_mis", 64'(bus.O_misalign), 64'd1);
`endif

        // Backpressure fill then drain
        step();
        drv(1, 5'b00001, '0, 32'h100, '0, '0, '0, 0, 0);
        step();
        drv(1, 5'b00001, '0, 32'h104, '0, '0, '0, 0, 0);
        step();
        drv(0, 5'b00001, '0, 32'h0, '0, '0, '0, 0, 0);
        probe();
        check("full_count", 64'(bus.O_count), 64'd2);
        check("full_ready", 64'(bus.O_in_ready), 64'd0);
        check("full_head", 64'(bus.O_dnpc), 64'h100);
        step();
        bus.I_dnpc_ready = 1'b1;
        probe();
        check("drain0", 64'(bus.O_dnpc), 64'h100);
        step();
        probe();
        check("drain1", 64'(bus.O_dnpc), 64'h104);
        check("drain1_valid", 64'(bus.O_dnpc_valid), 64'd1);
        step();
        probe();
        check("drain_count", 64'(bus.O_count), 64'd0);

        // Flush with two queued and an incoming request
        step();
        drv(1, 5'b00001, '0, 32'h200, '0, '0, '0, 0, 0);
        step();
        drv(1, 5'b00001, '0, 32'h204, '0, '0, '0, 0, 0);
        step();
        drv(1, 5'b00001, '0, 32'h208, '0, '0, '0, 0, 1);
        probe();
        check("flush_valid0", 64'(bus.O_dnpc_valid), 64'd0);
        check("flush_ready0", 64'(bus.O_in_ready), 64'd0);
        step();
        drv(0, 5'b00001, '0, 32'h0, '0, '0, '0, 0, 0);
        probe();
        check("post_flush_count", 64'(bus.O_count), 64'd0);
        check("post_flush_ready", 64'(bus.O_in_ready), 64'd1);
        check("post_flush_valid", 64'(bus.O_dnpc_valid), 64'd0);

        // Priority and wrap
        step();
        drv(1, 5'b10001, '0, 32'h40, '0, '0, 64'h8000_0100, 1, 0);
        probe();
        check("prio_dnpc", 64'(bus.O_dnpc), 64'h8000_0100);
        step();
        drv(1, 5'b00010, 32'hFFFF_FFFC, '0, '0, 64'h8, '0, 1, 0);
        probe();
        check("wrap_dnpc", 64'(bus.O_dnpc), 64'h4);

        // Reset with one entry queued
        step();
        drv(1, 5'b00001, '0, 32'h300, '0, '0, '0, 0, 0);
        step();
        drv(0, 5'b00001, '0, 32'h0, '0, '0, '0, 0, 0);
        rst_n = 1'b0;
        probe();
        check("mid_rst_valid", 64'(bus.O_dnpc_valid), 64'd0);
        check("mid_rst_dnpc", 64'(bus.O_dnpc), 64'd0);
        step();
        rst_n = 1'b1;
        drv(1, 5'b00100, 32'h1000, '0, '0, 64'h4, '0, 1, 0);
        probe();
        check("post_rst_count", 64'(bus.O_count), 64'd0);
        check("post_rst_ready", 64'(bus.O_in_ready), 64'd1);
        check("post_rst_dnpc", 64'(bus.O_dnpc), 64'h1004);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            sel  = 5'($urandom);
            if ($urandom_range(0, 2) == 0) sel = 5'(1 << $urandom_range(0, 4));
            rpc  = 32'($urandom);
            rimm = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 64)) : {$urandom, $urandom};
            drv(1'($urandom_range(0, 3) != 0), sel, rpc, rpc + 32'd4, {$urandom, $urandom},
                rimm, {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
                $urandom_range(0, 29) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
        end

        step();
        rst_n = 1'b1;
        drv(0, 5'b0, '0, '0, '0, '0, '0, 1, 0);
        repeat (DEPTH + 2) step();
        probe();
        check("final_drain", 64'(sbq.size()), 64'd0);
        check("final_count", 64'(bus.O_count), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
